// File: rtl/dmem_pkg.sv
// Shared constants for the dmem arbiter: bus widths, starvation limit and grant encoding.
package dmem_pkg;

  localparam int unsigned DATA_WHITH       = 32;
  localparam int unsigned DATA_SIZE        = 8;
  localparam int unsigned ADDR_WHITH       = 10;
  localparam int unsigned DATA_BYTE        = DATA_WHITH / DATA_SIZE;
  localparam int unsigned STARVE_MAX_DFLT  = 4;
  localparam int unsigned STARVE_W         = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_LSU  = 2'b01,
    GNT_PTW  = 2'b10,
    GNT_BOTH = 2'b11
  } gnt_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// LSU, PTW and 2R1W dmem signal bundle; slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [DATA_BYTE-1:0]  lsu_req_wmask;
  logic [ADDR_WHITH-1:0] lsu_req_addr;
  logic [DATA_WHITH-1:0] lsu_req_wdata;
  logic                  lsu_rsp_valid;
  logic [DATA_WHITH-1:0] lsu_rsp_rdata;

  logic                  ptw_req_valid;
  logic                  ptw_req_ready;
  logic [ADDR_WHITH-1:0] ptw_req_addr;
  logic                  ptw_rsp_valid;
  logic [DATA_WHITH-1:0] ptw_rsp_rdata;

  logic                  dmem_en;
  logic [DATA_BYTE-1:0]  dmem_wen;
  logic [ADDR_WHITH-1:0] dmem_addr1;
  logic [ADDR_WHITH-1:0] dmem_addr2;
  logic [DATA_WHITH-1:0] dmem_wdata;
  logic [DATA_WHITH-1:0] dmem_rdata1;
  logic [DATA_WHITH-1:0] dmem_rdata2;

  modport slave (
    input  lsu_req_valid, lsu_req_wmask, lsu_req_addr, lsu_req_wdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  ptw_req_valid, ptw_req_addr,
    output ptw_req_ready, ptw_rsp_valid, ptw_rsp_rdata,
    output dmem_en, dmem_wen, dmem_addr1, dmem_addr2, dmem_wdata,
    input  dmem_rdata1, dmem_rdata2
  );

  modport master (
    output lsu_req_valid, lsu_req_wmask, lsu_req_addr, lsu_req_wdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output ptw_req_valid, ptw_req_addr,
    input  ptw_req_ready, ptw_rsp_valid, ptw_rsp_rdata,
    input  dmem_en, dmem_wen, dmem_addr1, dmem_addr2, dmem_wdata,
    output dmem_rdata1, dmem_rdata2
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive PTW denials; sat tells the arbiter to let the PTW win.
module dmem_arb_starve_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign sat = (cnt == STARVE_W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the 2R1W dmem between LSU (port 1, r/w) and PTW (read port 2).
// Optional DMEM_ARB_PERF_EN adds conflict and PTW-stall performance counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]    perf_conflict_cnt,
  output logic [31:0]    perf_ptw_stall_cnt
`endif
);

  gnt_e                  gnt;
  logic                  lsu_wr;
  logic                  conflict;
  logic                  ptw_sat;
  logic                  lsu_gnt;
  logic                  ptw_gnt;
  logic [ADDR_WHITH-1:0] addr1;
  logic [ADDR_WHITH-1:0] addr2;
  logic [ADDR_WHITH-1:0] addr1_q;
  logic [ADDR_WHITH-1:0] addr2_q;

  assign lsu_wr   = bus.lsu_req_valid && (bus.lsu_req_wmask != '0);
  assign conflict = lsu_wr && bus.ptw_req_valid;

  // A write drives both read ports, so it excludes the PTW unless the PTW has starved.
  always_comb begin
    gnt = GNT_NONE;
    case ({bus.lsu_req_valid, bus.ptw_req_valid})
      2'b10:   gnt = GNT_LSU;
      2'b01:   gnt = GNT_PTW;
      2'b11: begin
        if (!conflict)    gnt = GNT_BOTH;
        else if (ptw_sat) gnt = GNT_PTW;
        else              gnt = GNT_LSU;
      end
      default: gnt = GNT_NONE;
    endcase
  end

  assign lsu_gnt = (gnt == GNT_LSU) || (gnt == GNT_BOTH);
  assign ptw_gnt = (gnt == GNT_PTW) || (gnt == GNT_BOTH);

  dmem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (conflict && !ptw_sat),
    .clr (!bus.ptw_req_valid || ptw_gnt),
    .sat (ptw_sat)
  );

  // Idle ports keep their previous address to avoid needless toggling.
  assign addr1 = lsu_gnt ? bus.lsu_req_addr :
                 ptw_gnt ? bus.ptw_req_addr : addr1_q;
  assign addr2 = ptw_gnt ? bus.ptw_req_addr : addr2_q;

  assign bus.lsu_req_ready = lsu_gnt && !rst;
  assign bus.ptw_req_ready = ptw_gnt && !rst;
  assign bus.dmem_en       = lsu_gnt || ptw_gnt;
  assign bus.dmem_wen      = (lsu_gnt && lsu_wr) ? bus.lsu_req_wmask : '0;
  assign bus.dmem_addr1    = addr1;
  assign bus.dmem_addr2    = addr2;
  assign bus.dmem_wdata    = bus.lsu_req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr1_q           <= '0;
      addr2_q           <= '0;
      bus.lsu_rsp_valid <= 1'b0;
      bus.lsu_rsp_rdata <= '0;
      bus.ptw_rsp_valid <= 1'b0;
      bus.ptw_rsp_rdata <= '0;
    end else begin
      addr1_q           <= addr1;
      addr2_q           <= addr2;
      bus.lsu_rsp_valid <= lsu_gnt;
      bus.ptw_rsp_valid <= ptw_gnt;
      if (lsu_gnt) bus.lsu_rsp_rdata <= lsu_wr ? '0 : bus.dmem_rdata1;
      if (ptw_gnt) bus.ptw_rsp_rdata <= bus.dmem_rdata2;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt  <= '0;
      perf_ptw_stall_cnt <= '0;
    end else begin
      if (conflict && (perf_conflict_cnt != '1))
        perf_conflict_cnt <= perf_conflict_cnt + 32'(1);
      if (bus.ptw_req_valid && !ptw_gnt && (perf_ptw_stall_cnt != '1))
        perf_ptw_stall_cnt <= perf_ptw_stall_cnt + 32'(1);
    end
  end
`endif

endmodule
